// File: rtl/decoder_stream.sv
// decoder_stream
//   Decodes one instruction word, then collects up to NUM_EXT trailing
//   extension words over a valid/ready stream and presents the complete
//   bundle to the issue stage on a valid/ready output.
//
//   Optional feature macro: DECODER_EXT_TIMEOUT_EN
//     Defined   : a wait counter aborts the extension fetch after TIMEOUT_CYC
//                 idle FETCH cycles and delivers the bundle with err=1.
//     Undefined : FETCH waits indefinitely, err is tied 0.
//
//   Ports
//     clk, rst (async active-low), flush (sync abort)
//     inst/inst_valid/inst_ready       instruction input stream
//     data/data_valid/data_ready       extension word input stream
//     opcode, mode, rsrc, rdest, flags decoded instruction fields
//     ext_bus, ext_present             extension slots and presence mask
//     decoded_valid                    flags[0] of the held instruction
//     out_valid/out_ready              bundle handoff
//     err                              bundle aborted by timeout
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_IDLE  | no bundle held, ready for an instruction
//   ST_FETCH | instruction held, collecting extension words
//   ST_OUT   | bundle complete, out_valid high until handed off
module decoder_stream #(
    parameter int DATA_W      = 64,
    parameter int INST_W      = 32,
    parameter int REG_W       = 6,
    parameter int NUM_EXT     = 3,
    parameter int MODE_W      = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic [INST_W-1:0]                         inst,
    input  logic                                      inst_valid,
    output logic                                      inst_ready,
    input  logic [DATA_W-1:0]                         data,
    input  logic                                      data_valid,
    output logic                                      data_ready,
    output logic [INST_W-MODE_W-2*REG_W-NUM_EXT-2:0]  opcode,
    output logic [MODE_W-1:0]                         mode,
    output logic [REG_W-1:0]                          rsrc,
    output logic [REG_W-1:0]                          rdest,
    output logic [NUM_EXT:0]                          flags,
    output logic [NUM_EXT*DATA_W-1:0]                 ext_bus,
    output logic [NUM_EXT-1:0]                        ext_present,
    output logic                                      decoded_valid,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      err
);

    localparam int FLAG_W = NUM_EXT + 1;
    localparam int OPC_W  = INST_W - MODE_W - 2*REG_W - FLAG_W;

    if (NUM_EXT < 1 || NUM_EXT > 8) begin : g_bad_num_ext
        $error("decoder_stream: NUM_EXT must be 1..8");
    end
    if (OPC_W < 1) begin : g_bad_opc_w
        $error("decoder_stream: opcode field width must be positive");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("decoder_stream: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t                     state_q;
    logic [OPC_W-1:0]           opcode_q;
    logic [MODE_W-1:0]          mode_q;
    logic [REG_W-1:0]           rsrc_q;
    logic [REG_W-1:0]           rdest_q;
    logic [FLAG_W-1:0]          flags_q;
    logic [NUM_EXT*DATA_W-1:0]  ext_q;
    logic [NUM_EXT-1:0]         pend_q;
    logic                       out_valid_q;
    logic                       err_q;

    logic                       inst_acc;
    logic [NUM_EXT-1:0]         pend_low;
    logic [NUM_EXT-1:0]         pend_rest;

`ifdef DECODER_EXT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]           cnt_q;
`endif

    // inst_ready is held low while reset is asserted so every output reads 0.
    assign inst_ready = rst & ~flush &
                        ((state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready));
    assign data_ready = ~flush & (state_q == ST_FETCH);
    assign inst_acc   = inst_valid & inst_ready;

    // Isolate the lowest pending slot: extension words arrive in ascending order.
    assign pend_low  = pend_q & (~pend_q + NUM_EXT'(1));
    assign pend_rest = pend_q & ~pend_low;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            mode_q      <= '0;
            rsrc_q      <= '0;
            rdest_q     <= '0;
            flags_q     <= '0;
            ext_q       <= '0;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef DECODER_EXT_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else if (flush) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (inst_acc) begin
            // Covers both the IDLE accept and the back-to-back accept in OUT.
            opcode_q <= inst[INST_W-1 -: OPC_W];
            mode_q   <= inst[INST_W-OPC_W-1 -: MODE_W];
            rsrc_q   <= inst[INST_W-OPC_W-MODE_W-1 -: REG_W];
            rdest_q  <= inst[FLAG_W+REG_W-1 -: REG_W];
            flags_q  <= inst[FLAG_W-1:0];
            ext_q    <= '0;
            pend_q   <= inst[NUM_EXT:1];
            err_q    <= 1'b0;
`ifdef DECODER_EXT_TIMEOUT_EN
            cnt_q    <= '0;
`endif
            if (inst[NUM_EXT:1] != '0) begin
                state_q     <= ST_FETCH;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= ST_OUT;
                out_valid_q <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (data_valid) begin
                        for (int k = 0; k < NUM_EXT; k++) begin
                            if (pend_low[k]) begin
                                ext_q[k*DATA_W +: DATA_W] <= data;
                            end
                        end
                        pend_q <= pend_rest;
`ifdef DECODER_EXT_TIMEOUT_EN
                        cnt_q  <= '0;
`endif
                        if (pend_rest == '0) begin
                            state_q     <= ST_OUT;
                            out_valid_q <= 1'b1;
                        end
                    end
`ifdef DECODER_EXT_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Missing slots keep the zeros loaded at accept.
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        pend_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign opcode        = opcode_q;
    assign mode          = mode_q;
    assign rsrc          = rsrc_q;
    assign rdest         = rdest_q;
    assign flags         = flags_q;
    assign ext_bus       = ext_q;
    assign ext_present   = flags_q[NUM_EXT:1];
    assign decoded_valid = flags_q[0];
    assign out_valid     = out_valid_q;
    assign err           = err_q;

endmodule

// File: tb/tb_decoder_stream.sv
// tb_decoder_stream
//   Directed scenarios followed by randomized traffic for decoder_stream.
//   A transaction-level reference (pending slot list, held word, stored
//   extension words) predicts handshakes and the delivered bundle each cycle.
//   Honours DECODER_EXT_TIMEOUT_EN when the bench is built with it defined.
module tb_decoder_stream;

    localparam int DATA_W      = 64;
    localparam int INST_W      = 32;
    localparam int REG_W       = 6;
    localparam int NUM_EXT     = 3;
    localparam int MODE_W      = 4;
    localparam int TIMEOUT_CYC = 4;
    localparam int FLAG_W      = NUM_EXT + 1;
    localparam int OPC_W       = INST_W - MODE_W - 2*REG_W - FLAG_W;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic [INST_W-1:0]         inst;
    logic                      inst_valid;
    logic                      inst_ready;
    logic [DATA_W-1:0]         data;
    logic                      data_valid;
    logic                      data_ready;
    logic [OPC_W-1:0]          opcode;
    logic [MODE_W-1:0]         mode;
    logic [REG_W-1:0]          rsrc;
    logic [REG_W-1:0]          rdest;
    logic [FLAG_W-1:0]         flags;
    logic [NUM_EXT*DATA_W-1:0] ext_bus;
    logic [NUM_EXT-1:0]        ext_present;
    logic                      decoded_valid;
    logic                      out_valid;
    logic                      out_ready;
    logic                      err;

    decoder_stream #(
        .DATA_W      (DATA_W),
        .INST_W      (INST_W),
        .REG_W       (REG_W),
        .NUM_EXT     (NUM_EXT),
        .MODE_W      (MODE_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .data          (data),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .opcode        (opcode),
        .mode          (mode),
        .rsrc          (rsrc),
        .rdest         (rdest),
        .flags         (flags),
        .ext_bus       (ext_bus),
        .ext_present   (ext_present),
        .decoded_valid (decoded_valid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference state: a bundle is either being collected (m_pend non-empty),
    // presented (m_have) or absent.
    bit                 m_have;
    int                 m_pend[$];
    logic [INST_W-1:0]  m_inst;
    logic [DATA_W-1:0]  m_ext[NUM_EXT];
    bit                 m_err;
    int                 m_wait;

    function automatic logic [255:0] exp_ext_bus();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < NUM_EXT; k++) r[k*DATA_W +: DATA_W] = m_ext[k];
        return r;
    endfunction

    task automatic model_reset();
        m_have = 0;
        m_pend.delete();
        m_inst = '0;
        for (int k = 0; k < NUM_EXT; k++) m_ext[k] = '0;
        m_err  = 0;
        m_wait = 0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_out_valid"},   out_valid,     0);
        check_eq({pfx, "_err"},         err,           0);
        check_eq({pfx, "_opcode"},      opcode,        0);
        check_eq({pfx, "_mode"},        mode,          0);
        check_eq({pfx, "_rsrc"},        rsrc,          0);
        check_eq({pfx, "_rdest"},       rdest,         0);
        check_eq({pfx, "_flags"},       flags,         0);
        check_eq({pfx, "_ext_bus"},     ext_bus,       0);
        check_eq({pfx, "_ext_present"}, ext_present,   0);
        check_eq({pfx, "_dec_valid"},   decoded_valid, 0);
        check_eq({pfx, "_inst_ready"},  inst_ready,    0);
        check_eq({pfx, "_data_ready"},  data_ready,    0);
    endtask

    // One clock: drive inputs after the falling edge, compare against the
    // reference, then advance the reference by what the rising edge does.
    task automatic step(input bit iv, input logic [INST_W-1:0] iw, input bit dv,
                        input logic [DATA_W-1:0] dw, input bit ordy, input bit fl);
        bit idle, e_ir, e_dr;
        longint unsigned w;
        @(negedge clk);
        inst_valid = iv;
        inst       = iw;
        data_valid = dv;
        data       = dw;
        out_ready  = ordy;
        flush      = fl;
        #1;
        idle = !m_have && (m_pend.size() == 0);
        e_ir = !fl && (idle || (m_have && ordy));
        e_dr = !fl && (m_pend.size() != 0);
        check_eq("inst_ready", inst_ready, e_ir);
        check_eq("data_ready", data_ready, e_dr);
        check_eq("out_valid",  out_valid,  m_have);
        check_eq("err",        err,        m_err);
        if (m_have) begin
            w = m_inst;
            check_eq("opcode",      opcode,        w >> (INST_W - OPC_W));
            check_eq("mode",        mode,          (w >> (2*REG_W + FLAG_W)) % (64'd1 << MODE_W));
            check_eq("rsrc",        rsrc,          (w >> (REG_W + FLAG_W)) % (64'd1 << REG_W));
            check_eq("rdest",       rdest,         (w >> FLAG_W) % (64'd1 << REG_W));
            check_eq("flags",       flags,         w % (64'd1 << FLAG_W));
            check_eq("ext_present", ext_present,   (w >> 1) % (64'd1 << NUM_EXT));
            check_eq("dec_valid",   decoded_valid, w % 2);
            check_eq("ext_bus",     ext_bus,       exp_ext_bus());
        end
        if (fl) begin
            m_have = 0;
            m_pend.delete();
            m_err  = 0;
        end else if (m_pend.size() != 0) begin
            if (dv) begin
                m_ext[m_pend.pop_front()] = dw;
                m_wait = 0;
                if (m_pend.size() == 0) m_have = 1;
            end else begin
`ifdef DECODER_EXT_TIMEOUT_EN
                m_wait++;
                if (m_wait == TIMEOUT_CYC) begin
                    m_pend.delete();
                    m_have = 1;
                    m_err  = 1;
                end
`endif
            end
        end else if (iv && e_ir) begin
            m_inst = iw;
            for (int k = 0; k < NUM_EXT; k++) m_ext[k] = '0;
            for (int k = 0; k < NUM_EXT; k++) if (iw[k+1]) m_pend.push_back(k);
            m_err  = 0;
            m_wait = 0;
            m_have = (m_pend.size() == 0);
        end else if (m_have && ordy) begin
            m_have = 0;
            m_err  = 0;
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; inst = '0; inst_valid = 1'b0;
        data = '0; data_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        check_all_zero("por");
        #9 rst = 1'b1;

        // Single disp word: only slot 1 is filled.
        step(1, 32'hABC1_2345, 0, '0, 0, 0);
        step(0, '0, 1, 64'hDEAD_BEEF, 0, 0);
        step(0, '0, 0, '0, 0, 0);
        check_eq("t2_out_valid",   out_valid,          1);
        check_eq("t2_slot1",       ext_bus[127:64],    64'hDEAD_BEEF);
        check_eq("t2_slot0",       ext_bus[63:0],      0);
        check_eq("t2_ext_present", ext_present,        3'b010);
        check_eq("t2_opcode",      opcode,             12'hABC);
        check_eq("t2_dec_valid",   decoded_valid,      1);
        step(0, '0, 0, '0, 1, 0);

        // All three slots with two-cycle gaps between beats.
        step(1, 32'h1234_567F, 0, '0, 0, 0);
        for (int b = 1; b <= 3; b++) begin
            step(0, '0, 0, '0, 0, 0);
            step(0, '0, 0, '0, 0, 0);
            step(0, '0, 1, 64'(b), 0, 0);
            if (b == 3) check_eq("t3_not_yet_valid", out_valid, 0);
        end
        step(0, '0, 0, '0, 0, 0);
        check_eq("t3_out_valid", out_valid, 1);
        check_eq("t3_slots",     ext_bus,   {64'd3, 64'd2, 64'd1});
        step(0, '0, 0, '0, 1, 0);

        // Back-to-back single-word instructions, then a 3-cycle stall.
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h0000_0001 | (32'(i + 1) << 20), 0, '0, 1, 0);
            if (i > 0) check_eq("t4_b2b_valid", out_valid, 1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 32'hFFF0_0001, 0, '0, 0, 0);
            check_eq("t4_stall_ready",  inst_ready, 0);
            check_eq("t4_stall_opcode", opcode,     12'h004);
        end
        step(0, '0, 0, '0, 1, 0);

        // Flush after one of three beats.
        step(1, 32'h0000_000F, 0, '0, 0, 0);
        step(0, '0, 1, 64'hAA, 0, 0);
        step(0, '0, 1, 64'hBB, 0, 1);
        step(0, '0, 1, 64'hCC, 0, 0);
        check_eq("t5_flush_valid", out_valid,  0);
        check_eq("t5_flush_dready", data_ready, 0);
        step(1, 32'h7770_0001, 0, '0, 0, 0);
        step(0, '0, 0, '0, 0, 0);
        check_eq("t5_next_valid",  out_valid, 1);
        check_eq("t5_next_opcode", opcode,    12'h777);
        check_eq("t5_next_ext",    ext_bus,   0);
        step(0, '0, 0, '0, 1, 0);

`ifdef DECODER_EXT_TIMEOUT_EN
        step(1, 32'h0000_0003, 0, '0, 0, 0);
        for (int i = 0; i < TIMEOUT_CYC; i++) step(0, '0, 0, '0, 0, 0);
        step(0, '0, 0, '0, 0, 0);
        check_eq("t6_to_valid", out_valid,     1);
        check_eq("t6_to_err",   err,           1);
        check_eq("t6_to_slot0", ext_bus[63:0], 0);
        step(0, '0, 0, '0, 1, 0);
        step(0, '0, 0, '0, 0, 0);
        check_eq("t6_err_clear", err, 0);
`endif

        // Asynchronous reset in the middle of a fetch.
        step(1, 32'h5550_000F, 0, '0, 0, 0);
        step(0, '0, 1, 64'h11, 0, 0);
        #2 rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        step(0, '0, 0, '0, 0, 0);
        check_eq("rst_rel_ready", inst_ready, 1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 4) != 0,
                 {$urandom, $urandom}, ($urandom % 4) != 0, ($urandom % 20) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_stream.md
Name: decoder_stream

Overview:
- Parametrised successor to the single-word instruction decoder.
- Decodes one instruction word, then collects up to NUM_EXT trailing 64-bit extension words (imm, disp, ext, ...) over a valid/ready data stream.
- Presents the complete decoded bundle on a valid/ready output to the issue stage.
- Sits between the fetch unit and issue; adds a flush input and full backpressure on every interface.

Parameters:
- DATA_W, 64, width of each trailing extension word.
- INST_W, 32, instruction word width.
- REG_W, 6, register specifier width.
- NUM_EXT, 3, number of optional trailing words (1..8); FLAG_W = NUM_EXT+1.
- MODE_W, 4, mode field width; OPC_W = INST_W-MODE_W-2*REG_W-FLAG_W (must be >0, 12 at defaults).
- TIMEOUT_CYC, 255, extension-wait limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of any in-flight decode
- inst  in  INST_W  instruction word
- inst_valid  in  1  inst offered
- inst_ready  out  1  decoder accepts inst
- data  in  DATA_W  extension word
- data_valid  in  1  data offered
- data_ready  out  1  decoder accepts data
- opcode  out  OPC_W  inst[INST_W-1 -: OPC_W]
- mode  out  MODE_W  next field down
- rsrc  out  REG_W  next field down
- rdest  out  REG_W  next field down
- flags  out  FLAG_W  inst[FLAG_W-1:0]
- ext_bus  out  NUM_EXT*DATA_W  word k at [k*DATA_W +: DATA_W]
- ext_present  out  NUM_EXT  bit k = flags[k+1]
- decoded_valid  out  1  flags[0] of held instruction
- out_valid  out  1  bundle complete and stable
- out_ready  in  1  consumer takes bundle
- err  out  1  bundle aborted by timeout (optional feature only, else tied 0)

Behaviour:
- Reset (rst low, async): state=IDLE; all outputs 0, including ext_bus, ext_present, out_valid, err; internal pending mask 0.
- States: IDLE, FETCH, OUT.
- inst_ready = (state==IDLE) | (state==OUT & out_ready). data_ready = (state==FETCH).
- Instruction accept (inst_valid & inst_ready):
  - Register all fields, flags and ext_present; clear ext_bus to 0.
  - Load pending = flags[NUM_EXT:1].
  - pending!=0 -> FETCH, else -> OUT.
  - Latency: out_valid asserts the cycle after accept when no extension words follow.
- FETCH:
  - Each data handshake stores data into the lowest set pending bit's ext slot, then clears that bit.
  - Extension words are consumed strictly in ascending index order; absent slots are skipped and stay 0.
  - When the last pending bit clears -> OUT (out_valid asserts the next cycle).
  - data_valid low: wait indefinitely; no state change.
- OUT:
  - out_valid=1; all bundle outputs held stable while out_ready=0.
  - out_ready=1 and no new inst: -> IDLE; out_valid drops next cycle.
  - out_ready=1 and inst_valid=1 in the same cycle: complete the handoff and accept the new inst back-to-back; out_valid stays high only if the new inst has no extension words (following cycle).
- decoded_valid: registered copy of flags[0]; meaningful only with out_valid. A bundle with flags[0]=0 is still delivered (consumer treats it as bubble).
- flush:
  - Priority over all handshakes; in any state -> IDLE next cycle.
  - out_valid=0 and pending=0; inst/data offered that cycle are not accepted (inst_ready, data_ready forced 0).
  - Held field values are don't-care.
- Throughput: 1 instruction per cycle with no extension words; 1+N cycles with N extension words, absent backpressure.

Optional Feature:
- Macro: DECODER_EXT_TIMEOUT_EN.
- Enabled:
  - Wait counter clears on entering FETCH and on each data handshake; increments each FETCH cycle without one.
  - On reaching TIMEOUT_CYC -> OUT with err=1 and the remaining pending slots 0.
  - err clears when that bundle is handed off, on flush, and on reset.
- Disabled: no counter logic; err tied 0; FETCH waits forever.

Test Plan:
- Reset mid-FETCH: drive rst low -> all outputs 0 asynchronously; IDLE after release; inst_ready=1 next edge.
- inst=0xABC1_2345 (flags=0x5: valid+imm... flags[2]=disp) -> FETCH; one data beat 0xDEAD_BEEF -> ext slot1=0xDEAD_BEEF, slot0=0, ext_present=3'b010, opcode=0xABC, decoded_valid=1.
- inst flags=0xF, data beats 1,2,3 with data_valid gaps of 2 cycles -> slots 0..2 = 1,2,3 in order; out_valid asserts the cycle after the third beat.
- Back-to-back flags=0x1 instructions with out_ready=1 -> one bundle per cycle; out_ready=0 for 3 cycles -> fields stable, inst_ready=0.
- flush asserted during FETCH after one of three beats -> IDLE next cycle; out_valid never asserts; the next instruction decodes cleanly.
- DECODER_EXT_TIMEOUT_EN, TIMEOUT_CYC=4, flags=0x3 with no data -> out_valid with err=1 after the 4 wait cycles, ext slot0=0.
